// File: rtl/game_pkg.sv
// Shared types and default timing constants for the BlackJack timing block.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  localparam int CLK_HZ_50M       = 50_000_000;
  localparam int TICK_HZ_DEFAULT  = 2_000;
  localparam int TIMEOUT_2S_TICKS = 4_000;

endpackage

// File: rtl/game_timer_if.sv
// Control and status bundle between the game FSM and the timing block.
interface game_timer_if #(
  parameter int WIDTH = 12
);

  logic             i_Enable;
  logic             i_Zero;
  logic             i_Start;
  logic [WIDTH-1:0] o_Count;
  logic             o_Wrap;
  logic             o_Tick;
  logic             o_Busy;
  logic             o_Done;

  modport master (
    output i_Enable, i_Zero, i_Start,
    input  o_Count, o_Wrap, o_Tick, o_Busy, o_Done
  );

  modport slave (
    input  i_Enable, i_Zero, i_Start,
    output o_Count, o_Wrap, o_Tick, o_Busy, o_Done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle tick every DIV clocks.
module tick_prescaler #(
  parameter int DIV = 25_000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int CW = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "tick_prescaler: DIV must be >= 2");
  end

  logic [CW-1:0] phase_q, phase_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d  = (phase_q == PHASE_LAST);
    phase_d = tick_d ? '0 : phase_q + 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign o_Tick = tick_q;

endmodule

// File: rtl/game_timer.sv
// Prescaler, modulo counter and retriggerable tick-based timeout on the 50 MHz clock.
module game_timer
  import game_pkg::*;
#(
  parameter int WIDTH         = 12,
  parameter int MODULO        = 2 ** WIDTH,
  parameter int CLK_HZ        = CLK_HZ_50M,
  parameter int TICK_HZ       = TICK_HZ_DEFAULT,
  parameter int TIMEOUT_TICKS = TIMEOUT_2S_TICKS
) (
  input  logic         clk_50M,
  input  logic         i_Reset,
  game_timer_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULO - 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TIMEOUT_TICKS - 1);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_div_check
    $fatal(1, "game_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (MODULO < 2 || MODULO > 2 ** WIDTH) begin : g_mod_check
    $fatal(1, "game_timer: MODULO must lie in 2..2**WIDTH");
  end
  if (TIMEOUT_TICKS < 1) begin : g_to_check
    $fatal(1, "game_timer: TIMEOUT_TICKS must be >= 1");
  end

  logic tick;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .o_Tick  (tick)
  );

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  timer_state_e     state_q, state_d;
  logic [TW-1:0]    ticks_q, ticks_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.i_Zero) begin
      count_d = '0;
    end else if (bus.i_Enable) begin
      if (count_q == COUNT_MAX) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // A start in any state (re)arms the timeout; a tick coinciding with it is dropped.
  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_Start) begin
          state_d = RUN;
          ticks_d = '0;
        end
      end
      RUN: begin
        if (bus.i_Start) begin
          ticks_d = '0;
        end else if (tick) begin
          if (ticks_q == TICK_LAST) state_d = DONE;
          else                      ticks_d = ticks_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_Start) begin
          state_d = RUN;
          ticks_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ticks_d = '0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      state_q <= IDLE;
      ticks_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
      ticks_q <= ticks_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_Count = count_q;
  assign bus.o_Wrap  = wrap_q;
  assign bus.o_Tick  = tick;
  assign bus.o_Busy  = busy_q;
  assign bus.o_Done  = done_q;

endmodule

// File: tb/tb_game_timer.sv
// Randomized and directed checks of game_timer against a countdown-style reference model.
module tb_game_timer;

  localparam int WIDTH         = 4;
  localparam int MODULO        = 10;
  localparam int CLK_HZ        = 10;
  localparam int TICK_HZ       = 2;
  localparam int TIMEOUT_TICKS = 3;
  localparam int DIV           = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  game_timer_if #(.WIDTH(WIDTH)) bus ();

  game_timer #(
    .WIDTH         (WIDTH),
    .MODULO        (MODULO),
    .CLK_HZ        (CLK_HZ),
    .TICK_HZ       (TICK_HZ),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk_50M (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: cycles since reset mod DIV, counter value, and ticks left before timeout.
  int m_phase   = 0;
  int m_count   = 0;
  int m_left    = 0;
  bit m_tick    = 1'b0;
  bit m_wrap    = 1'b0;
  bit m_running = 1'b0;
  bit m_done    = 1'b0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit e, input bit z, input bit s);
    bit tick_seen;
    if (r) begin
      m_phase = 0; m_count = 0; m_left = 0;
      m_tick = 0; m_wrap = 0; m_running = 0; m_done = 0;
    end else begin
      tick_seen = m_tick;
      m_phase   = (m_phase + 1) % DIV;
      m_tick    = (m_phase == 0);
      if (z) begin
        m_count = 0; m_wrap = 0;
      end else if (e) begin
        m_wrap  = (m_count == MODULO - 1);
        m_count = (m_count + 1) % MODULO;
      end else begin
        m_wrap = 0;
      end
      m_done = 0;
      if (s) begin
        m_running = 1; m_left = TIMEOUT_TICKS;
      end else if (m_running && tick_seen) begin
        m_left--;
        if (m_left == 0) begin
          m_running = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit z, input bit s);
    rst          = r;
    bus.i_Enable = e;
    bus.i_Zero   = z;
    bus.i_Start  = s;
    @(posedge clk);
    modelStep(r, e, z, s);
    #1;
    checkOutput("count", int'(bus.o_Count), m_count);
    checkOutput("wrap",  int'(bus.o_Wrap),  int'(m_wrap));
    checkOutput("tick",  int'(bus.o_Tick),  int'(m_tick));
    checkOutput("busy",  int'(bus.o_Busy),  int'(m_running));
    checkOutput("done",  int'(bus.o_Done),  int'(m_done));
    checkOutput("busy_done_excl", int'(bus.o_Busy & bus.o_Done), 0);
  endtask

  task automatic measureTimeout(output int dur);
    applyStimulus(0, 0, 0, 1);
    checkOutput("busy_after_start", int'(bus.o_Busy), 1);
    dur = 1;
    while (!bus.o_Done && dur < 40) begin
      applyStimulus(0, 0, 0, 0);
      dur++;
    end
    checkOutput("timeout_seen", int'(bus.o_Done), 1);
    checkOutput("timeout_window", int'(dur >= 12 && dur <= 16), 1);
  endtask

  initial begin
    int n;
    int dur;
    bus.i_Enable = 1'b0;
    bus.i_Zero   = 1'b0;
    bus.i_Start  = 1'b0;

    $display("[TB] reset and prescaler");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (bus.o_Tick) n++;
    end
    checkOutput("ticks_in_15", n, 3);

    $display("[TB] counter wrap and zero priority");
    applyStimulus(0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 0, 0);
      if (bus.o_Wrap) n++;
    end
    checkOutput("wrap_pulses", n, 1);
    checkOutput("count_after_12", int'(bus.o_Count), 2);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("count_seven", int'(bus.o_Count), 7);
    applyStimulus(0, 1, 1, 0);
    checkOutput("zero_wins_count", int'(bus.o_Count), 0);
    checkOutput("zero_wins_wrap", int'(bus.o_Wrap), 0);

    $display("[TB] timeout");
    measureTimeout(dur);
    applyStimulus(0, 0, 0, 0);
    checkOutput("done_one_cycle", int'(bus.o_Done), 0);

    $display("[TB] retrigger");
    applyStimulus(0, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (bus.o_Tick) n++;
    end
    checkOutput("two_ticks_seen", n, 2);
    checkOutput("still_busy", int'(bus.o_Busy), 1);
    measureTimeout(dur);

    $display("[TB] start during done");
    applyStimulus(0, 0, 0, 0);
    measureTimeout(dur);
    applyStimulus(0, 0, 0, 1);
    checkOutput("restart_busy", int'(bus.o_Busy), 1);
    checkOutput("restart_done", int'(bus.o_Done), 0);

    $display("[TB] reset mid-run");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset_busy", int'(bus.o_Busy), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (bus.o_Done) n++;
    end
    checkOutput("no_done_after_reset", n, 0);
    checkOutput("reset_count", int'(bus.o_Count), 0);

    $display("[TB] random");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(199) == 0, $urandom_range(1) == 1,
                    $urandom_range(9) == 0, $urandom_range(39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Parametrised timing and counting block for the BlackJack FPGA datapath. It runs entirely on the 50 MHz system clock and contains three parts:
- a prescaler that produces a one-cycle tick enable at a configurable rate, replacing the separate slow-clock domain;
- a modulo counter with enable and clear, used for card index and seed generation;
- a retriggerable tick-based timeout with start/busy/done handshake, used by the game FSM for display and hold delays (default 2 s).

## Interface
- WIDTH, 12: width of o_Count.
- MODULO, 2**WIDTH: count modulus. o_Count runs 0..MODULO-1. Legal range 2..2**WIDTH.
- CLK_HZ, 50_000_000: clk_50M frequency.
- TICK_HZ, 2_000: tick rate. DIV = CLK_HZ/TICK_HZ; must be an integer ≥ 2.
- TIMEOUT_TICKS, 4_000: timeout length in ticks. Must be ≥ 1.

Ports:
- clk_50M  in  1  system clock; the only clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  increment o_Count on this clock edge.
- i_Zero  in  1  synchronous clear of o_Count.
- i_Start  in  1  single-cycle pulse; start or restart the timeout.
- o_Count  out  WIDTH  modulo counter value.
- o_Wrap  out  1  one-cycle pulse: count wrapped MODULO-1 → 0.
- o_Tick  out  1  one-cycle tick enable, once every DIV cycles.
- o_Busy  out  1  timeout running.
- o_Done  out  1  one-cycle pulse: timeout expired (successor of the old two-second flag).

## Operation
- Reset (i_Reset=1 at an edge) has priority over every other input. After reset: all outputs 0, prescaler 0, timer state IDLE, tick count 0.
- **Prescaler**
  - Free-running counter 0..DIV-1; wraps to 0.
  - o_Tick is registered and is 1 in the cycle after the prescaler passes DIV-1, so exactly one tick per DIV cycles.
  - The first o_Tick after reset is in cycle DIV.
  - i_Start does not resynchronise the prescaler.
- **Modulo counter**
  - i_Zero=1: o_Count ← 0 and o_Wrap ← 0. i_Zero wins over i_Enable.
  - Otherwise, i_Enable=1: o_Count ← o_Count+1, or 0 if o_Count=MODULO-1. o_Wrap ← 1 only on that wrap.
  - Otherwise o_Count holds and o_Wrap ← 0.
- **Timer FSM** (states IDLE, RUN, DONE; registered)
  - IDLE: i_Start → RUN, tick count ← 0.
  - RUN:
    - i_Start → stay in RUN, tick count ← 0 (retrigger; that cycle's tick is discarded).
    - Else, if o_Tick=1: if tick count = TIMEOUT_TICKS-1 → DONE; otherwise tick count +1.
  - DONE: lasts one cycle, then → IDLE. i_Start during DONE → RUN with tick count 0; o_Done is still asserted in that DONE cycle.
  - Outputs: o_Busy = (state==RUN); o_Done = (state==DONE).
  - The tick count is $clog2(TIMEOUT_TICKS) bits wide and never exceeds TIMEOUT_TICKS-1.
- Parameter violations (DIV<2, MODULO out of range, TIMEOUT_TICKS<1) are rejected at elaboration with a fatal message.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Counter latency: o_Count and o_Wrap update 1 cycle after the i_Enable/i_Zero sample.
- Start latency: o_Busy rises 1 cycle after the i_Start sample.
- Timeout duration: o_Done pulses 1 cycle after the edge that samples the TIMEOUT_TICKS-th o_Tick seen while in RUN.
  - An o_Tick in the same cycle as i_Start is not counted.
  - Start-to-done is therefore between (TIMEOUT_TICKS-1)·DIV+2 and TIMEOUT_TICKS·DIV+1 cycles, depending on prescaler phase.
- o_Busy and o_Done are never both 1.
- i_Reset asserted mid-RUN: the next cycle is IDLE with o_Busy=0, and no o_Done is emitted.

## Structure
- Shared package game_pkg holds:
  - the timer state enum (IDLE/RUN/DONE);
  - the default constants CLK_HZ_50M=50_000_000, TICK_HZ_DEFAULT=2_000, TIMEOUT_2S_TICKS=4_000.
- One sub-module: tick_prescaler, parameterised by DIV, with ports clk_50M, i_Reset, o_Tick.
- The modulo counter and timer FSM stay in game_timer.

## Test plan
Unless noted, benches use WIDTH=4, MODULO=10, CLK_HZ=10, TICK_HZ=2 (DIV=5), TIMEOUT_TICKS=3.
- **Reset / prescaler:** hold i_Reset 3 cycles, then release.
  - All outputs read 0 during reset.
  - o_Tick pulses in cycles 5, 10, 15 after release, each one cycle wide.
- **Counter wrap:** i_Enable=1 for 12 cycles.
  - o_Count reads 1..9, 0, 1, 2.
  - o_Wrap is 1 only in the cycle o_Count reads 0.
- **Zero priority:** o_Count=7; drive i_Zero=1 and i_Enable=1 together → o_Count=0 next cycle and o_Wrap=0.
- **Timeout:** pulse i_Start.
  - o_Busy=1 from the next cycle.
  - After the 3rd o_Tick, o_Busy=0 and o_Done=1 for exactly one cycle.
  - Measured duration lies within 12..16 cycles.
- **Retrigger / start in DONE:**
  - i_Start after the 2nd tick restarts the count, so o_Done comes 3 ticks later.
  - i_Start coincident with DONE gives o_Done=1 in that cycle, then o_Busy=1 with no gap.
- **Reset mid-run:** i_Reset during RUN.
  - o_Busy=0 next cycle.
  - No o_Done pulse for the next 20 cycles.
  - o_Count=0.
